// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests a word at PC, holds it for decode, then redirects the PC (jump / taken BEQ / +4) on consume.
// One cycle from imem_ack to instr_valid; the held instruction waits indefinitely for instr_ready, giving at best one instruction per 2 cycles.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] pc_plus4_w;
    logic [31:0] br_off_w;
    logic [31:0] next_pc_w;

    assign pc_plus4_w = pc_q + 32'd4;
    // Word offset sign-extended and scaled to bytes; wraps naturally modulo 2^32.
    assign br_off_w   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        next_pc_w = pc_plus4_w;
        if (jump) begin
            next_pc_w = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc_w = pc_plus4_w + br_off_w;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d      = next_pc_w;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == HOLD);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_plus4    = pc_plus4_w;
    assign retired     = retired_q;

endmodule
